// File: rtl/mdio_pkg.sv
// MDIO management frame constants, field widths and FSM encoding.
// Shared by the master RTL and the PHY-side emulation in benches.
package mdio_pkg;

  localparam int PHY_W   = 5;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = 32;

  localparam logic [1:0] START_PAT = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] TA_WR     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_START,
    ST_OPCODE,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_DATA
  } mdio_state_e;

  function automatic logic [7:0] field_len(input mdio_state_e s);
    case (s)
      ST_START:  return 8'd2;
      ST_OPCODE: return 8'd2;
      ST_PHYAD:  return 8'(PHY_W);
      ST_REGAD:  return 8'(REG_W);
      ST_TA:     return 8'd2;
      ST_DATA:   return 8'(DATA_W);
      default:   return 8'd1;
    endcase
  endfunction

  function automatic mdio_state_e next_field(input mdio_state_e s);
    case (s)
      ST_PREAMBLE: return ST_START;
      ST_START:    return ST_OPCODE;
      ST_OPCODE:   return ST_PHYAD;
      ST_PHYAD:    return ST_REGAD;
      ST_REGAD:    return ST_TA;
      ST_TA:       return ST_DATA;
      default:     return ST_IDLE;
    endcase
  endfunction

  // Everything after the preamble, MSB first; read data slots are don't-care.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              rw,
    input logic [PHY_W-1:0]  phy,
    input logic [REG_W-1:0]  rg,
    input logic [DATA_W-1:0] wd
  );
    return {START_PAT, rw ? OP_READ : OP_WRITE, phy, rg, TA_WR,
            rw ? {DATA_W{1'b0}} : wd};
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: low half then high half per bit period.
// Emits a strobe on the last cycle of a bit and on the cycle MDC rises.
module mdio_mdc_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_mdc,
  output logic o_bit_start,
  output logic o_rise
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_mdc;

  assign o_mdc       = r_mdc;
  assign o_bit_start = i_en && (r_cnt == LAST);
  assign o_rise      = i_en && (r_cnt == HALF);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_mdc <= (r_cnt >= HALF);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: preamble, frame shift-out,
// turnaround and read-data capture with a split tri-state MDIO.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rw,
  input  logic [4:0]  i_req_phy_addr,
  input  logic [4:0]  i_req_reg_addr,
  input  logic [15:0] i_req_wdata,
  output logic [15:0] o_rdata,
  output logic        o_done,
  output logic        o_rd_err,
  output logic        o_busy,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  mdio_state_e   r_state;
  logic [7:0]    r_cnt;
  logic [31:0]   r_tx;
  logic [15:0]   r_rx;
  logic [15:0]   r_rdata;
  logic          r_rw;
  logic          r_err;
  logic          r_out;
  logic          r_oe;
  logic          r_done;
  logic          r_rd_err;

  logic          w_busy;
  logic          w_accept;
  logic          w_bit_start;
  logic          w_rise;
  logic          w_mdc;
  logic          w_last;
  logic          w_end;
  logic          w_adv;
  logic          w_pre;
  logic          w_shift;
  mdio_state_e   w_next;
  logic [31:0]   w_frame;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = i_req_valid && !w_busy;
  assign w_last   = (r_cnt == 8'd0);
  assign w_next   = next_field(r_state);
  assign w_frame  = build_frame(i_req_rw, i_req_phy_addr,
                                i_req_reg_addr, i_req_wdata);

  assign w_end   = w_last && (r_state == ST_DATA);
  assign w_adv   = w_last && (r_state != ST_DATA);
  assign w_pre   = !w_last && (r_state == ST_PREAMBLE);
  assign w_shift = !w_last && (r_state != ST_PREAMBLE);

  mdio_mdc_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_mdc (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clr      (w_accept),
    .i_en       (w_busy),
    .o_mdc      (w_mdc),
    .o_bit_start(w_bit_start),
    .o_rise     (w_rise)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_rw     <= 1'b0;
      r_err    <= 1'b0;
      r_out    <= 1'b1;
      r_oe     <= 1'b0;
      r_done   <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_busy) begin
        if (i_req_valid) begin
          r_rw  <= i_req_rw;
          r_err <= 1'b0;
          r_oe  <= 1'b1;
          if (PREAMBLE_LEN > 0) begin
            r_state <= ST_PREAMBLE;
            r_cnt   <= 8'(PREAMBLE_LEN - 1);
            r_out   <= 1'b1;
            r_tx    <= w_frame;
          end else begin
            r_state <= ST_START;
            r_cnt   <= 8'd1;
            r_out   <= w_frame[31];
            r_tx    <= {w_frame[30:0], 1'b0};
          end
        end
      end else begin
        // Second TA bit is the PHY's acknowledge slot; 1 means nobody answered.
        if (w_rise) begin
          if (r_state == ST_TA && w_last)
            r_err <= i_mdio_in;
          if (r_state == ST_DATA)
            r_rx <= {r_rx[14:0], i_mdio_in};
        end
        if (w_bit_start) begin
          unique case (1'b1)
            w_end: begin
              r_state  <= ST_IDLE;
              r_out    <= 1'b1;
              r_oe     <= 1'b0;
              r_done   <= 1'b1;
              r_rd_err <= r_rw & r_err;
              if (r_rw)
                r_rdata <= r_rx;
            end
            w_adv: begin
              r_state <= w_next;
              r_cnt   <= field_len(w_next) - 8'd1;
              r_out   <= r_tx[31];
              r_tx    <= {r_tx[30:0], 1'b0};
              if (w_next == ST_TA && r_rw)
                r_oe <= 1'b0;
            end
            w_pre: begin
              r_cnt <= r_cnt - 8'd1;
              r_out <= 1'b1;
            end
            w_shift: begin
              r_cnt <= r_cnt - 8'd1;
              r_out <= r_tx[31];
              r_tx  <= {r_tx[30:0], 1'b0};
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_req_ready = !w_busy;
  assign o_busy      = w_busy;
  assign o_mdc       = w_mdc;
  assign o_mdio_out  = r_out;
  assign o_mdio_oe   = r_oe;
  assign o_rdata     = r_rdata;
  assign o_done      = r_done;
  assign o_rd_err    = r_rd_err;

endmodule
